// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller: forwarding selects,
// result-source encoding and the multi-cycle sequencer states.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_e;

    // Memory wins over Writeback because it holds the younger result for the register.
    function automatic fwd_sel_e fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic [4:0] rd_w,
        input logic       we_m,
        input logic       we_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return FWD_MEM;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return FWD_WB;
        end else begin
            return FWD_RF;
        end
    endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Combinational operand-forwarding selects for both Execute source operands.
module forwarding_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs1_e,
    input  logic [4:0] rs2_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output fwd_sel_e   forward_a,
    output fwd_sel_e   forward_b
);

    assign forward_a = fwd_select(rs1_e, rd_m, rd_w, reg_write_m, reg_write_w);
    assign forward_b = fwd_select(rs2_e, rd_m, rd_w, reg_write_m, reg_write_w);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding control for the five-stage pipeline, plus the sequencer that
// holds the front end while a multi-cycle Execute op runs and the two perf counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MC_LAT = 32,
    parameter int CNT_W  = $clog2(MC_LAT)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  rs1_d_i,
    input  logic [4:0]  rs2_d_i,
    input  logic [4:0]  rs1_e_i,
    input  logic [4:0]  rs2_e_i,
    input  logic [4:0]  rd_e_i,
    input  logic [4:0]  rd_m_i,
    input  logic [4:0]  rd_w_i,
    input  logic        reg_write_m_i,
    input  logic        reg_write_w_i,
    input  logic [1:0]  result_src_e_i,
    input  logic        pc_src_e_i,
    input  logic        mc_start_e_i,
    output logic        stall_f_o,
    output logic        stall_d_o,
    output logic        stall_e_o,
    output logic        flush_d_o,
    output logic        flush_e_o,
    output logic        flush_m_o,
    output logic [1:0]  forward_a_e_o,
    output logic [1:0]  forward_b_e_o,
    output logic        mc_busy_o,
    output logic        mc_done_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    // The start cycle itself is a stall cycle, so the counter covers the remaining MC_LAT-2.
    localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LAT - 2);

    mc_state_e        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             mc_stall_raw, mc_done_raw;
    logic             mc_stall, mc_done;
    logic             lw_stall;
    logic [31:0]      stall_cnt, flush_cnt;
    fwd_sel_e         fwd_a, fwd_b;

    forwarding_unit u_forwarding_unit (
        .rs1_e       (rs1_e_i),
        .rs2_e       (rs2_e_i),
        .rd_m        (rd_m_i),
        .rd_w        (rd_w_i),
        .reg_write_m (reg_write_m_i),
        .reg_write_w (reg_write_w_i),
        .forward_a   (fwd_a),
        .forward_b   (fwd_b)
    );

    assign forward_a_e_o = fwd_a;
    assign forward_b_e_o = fwd_b;

    assign lw_stall = (result_src_e_i == RESULT_SRC_LOAD) && (rd_e_i != 5'd0) &&
                      ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        mc_stall_raw = 1'b0;
        mc_done_raw  = 1'b0;
        case (state)
            IDLE: begin
                if (mc_start_e_i) begin
                    mc_stall_raw = 1'b1;
                    cnt_n        = MC_LOAD;
                    state_n      = BUSY;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    mc_stall_raw = 1'b1;
                    cnt_n        = cnt - CNT_W'(1);
                end else begin
                    mc_done_raw  = 1'b1;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The IDLE start path is combinational, so mask it so nothing sequencer-driven leaks out in reset.
    assign mc_stall = mc_stall_raw & ~rst_i;
    assign mc_done  = mc_done_raw & ~rst_i;

    assign mc_busy_o = mc_stall;
    assign mc_done_o = mc_done;
    assign stall_f_o = lw_stall | mc_stall;
    assign stall_d_o = lw_stall | mc_stall;
    assign stall_e_o = mc_stall;
    assign flush_m_o = mc_stall;
    assign flush_d_o = pc_src_e_i & ~mc_stall;
    assign flush_e_o = (lw_stall | pc_src_e_i) & ~mc_stall;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_f_o) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush_d_o) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl; a MC_LAT=4 and a MC_LAT=2 instance share stimulus.
module tb_pipeline_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  rs1_d_i, rs2_d_i, rs1_e_i, rs2_e_i, rd_e_i, rd_m_i, rd_w_i;
    logic        reg_write_m_i, reg_write_w_i;
    logic [1:0]  result_src_e_i;
    logic        pc_src_e_i, mc_start_e_i;

    logic        stall_f_o, stall_d_o, stall_e_o, flush_d_o, flush_e_o, flush_m_o;
    logic [1:0]  forward_a_e_o, forward_b_e_o;
    logic        mc_busy_o, mc_done_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    logic        stall_f2, stall_d2, stall_e2, flush_d2, flush_e2, flush_m2;
    logic [1:0]  forward_a2, forward_b2;
    logic        mc_busy2, mc_done2;
    logic [31:0] stall_cnt2, flush_cnt2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    pipeline_hazard_ctrl #(.MC_LAT(4)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i),
        .rs1_d_i(rs1_d_i), .rs2_d_i(rs2_d_i), .rs1_e_i(rs1_e_i), .rs2_e_i(rs2_e_i),
        .rd_e_i(rd_e_i), .rd_m_i(rd_m_i), .rd_w_i(rd_w_i),
        .reg_write_m_i(reg_write_m_i), .reg_write_w_i(reg_write_w_i),
        .result_src_e_i(result_src_e_i), .pc_src_e_i(pc_src_e_i), .mc_start_e_i(mc_start_e_i),
        .stall_f_o(stall_f_o), .stall_d_o(stall_d_o), .stall_e_o(stall_e_o),
        .flush_d_o(flush_d_o), .flush_e_o(flush_e_o), .flush_m_o(flush_m_o),
        .forward_a_e_o(forward_a_e_o), .forward_b_e_o(forward_b_e_o),
        .mc_busy_o(mc_busy_o), .mc_done_o(mc_done_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    pipeline_hazard_ctrl #(.MC_LAT(2)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i),
        .rs1_d_i(rs1_d_i), .rs2_d_i(rs2_d_i), .rs1_e_i(rs1_e_i), .rs2_e_i(rs2_e_i),
        .rd_e_i(rd_e_i), .rd_m_i(rd_m_i), .rd_w_i(rd_w_i),
        .reg_write_m_i(reg_write_m_i), .reg_write_w_i(reg_write_w_i),
        .result_src_e_i(result_src_e_i), .pc_src_e_i(pc_src_e_i), .mc_start_e_i(mc_start_e_i),
        .stall_f_o(stall_f2), .stall_d_o(stall_d2), .stall_e_o(stall_e2),
        .flush_d_o(flush_d2), .flush_e_o(flush_e2), .flush_m_o(flush_m2),
        .forward_a_e_o(forward_a2), .forward_b_e_o(forward_b2),
        .mc_busy_o(mc_busy2), .mc_done_o(mc_done2),
        .stall_cnt_o(stall_cnt2), .flush_cnt_o(flush_cnt2)
    );

    // A taken branch can never resolve while a multi-cycle op owns Execute.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(mc_busy_o && pc_src_e_i))
                else $error("[TB] FAIL pc_src_during_busy: got pc_src=1 busy=1, need pc_src=0");
        end
    end

    task automatic clear_inputs();
        rs1_d_i = 5'd0; rs2_d_i = 5'd0; rs1_e_i = 5'd0; rs2_e_i = 5'd0;
        rd_e_i = 5'd0; rd_m_i = 5'd0; rd_w_i = 5'd0;
        reg_write_m_i = 1'b0; reg_write_w_i = 1'b0;
        result_src_e_i = 2'b00; pc_src_e_i = 1'b0; mc_start_e_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        clear_inputs();
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        clear_inputs();
        rst_i = 1'b1;
        mc_start_e_i = 1'b1;
        #1;
        vectors++;
        if ({mc_busy_o, mc_done_o, stall_e_o, flush_m_o} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_mc_outputs: got %b, need 0000", {mc_busy_o, mc_done_o, stall_e_o, flush_m_o});
        end
        @(posedge clk_i);
        #1;
        vectors++;
        if ({stall_cnt_o, flush_cnt_o} !== 64'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_counters: got %h/%h, need 0/0", stall_cnt_o, flush_cnt_o);
        end
        @(negedge clk_i);
        mc_start_e_i = 1'b0;
        rst_i = 1'b0;
        #1;
        vectors++;
        if ({stall_f_o, stall_d_o, stall_e_o, flush_d_o, flush_e_o, flush_m_o, mc_busy_o} !== 7'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_idle_ctrl: got %b, need 0000000",
                     {stall_f_o, stall_d_o, stall_e_o, flush_d_o, flush_e_o, flush_m_o, mc_busy_o});
        end
    endtask

    task automatic test_forwarding();
        @(negedge clk_i);
        rs1_e_i = 5'd5; rd_m_i = 5'd5; rd_w_i = 5'd5;
        reg_write_m_i = 1'b1; reg_write_w_i = 1'b1;
        #1;
        vectors++;
        if ({forward_a_e_o, forward_b_e_o} !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL fwd_mem_priority: got a=%b b=%b, need a=10 b=00", forward_a_e_o, forward_b_e_o);
        end
        reg_write_m_i = 1'b0;
        #1;
        vectors++;
        if (forward_a_e_o !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL fwd_wb: got %b, need 01", forward_a_e_o);
        end
        rd_m_i = 5'd0; rd_w_i = 5'd0; rs1_e_i = 5'd0;
        reg_write_m_i = 1'b1;
        #1;
        vectors++;
        if ({forward_a_e_o, forward_b_e_o} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL fwd_x0: got a=%b b=%b, need a=00 b=00", forward_a_e_o, forward_b_e_o);
        end
        rs1_e_i = 5'd3; rd_m_i = 5'd3; rs2_e_i = 5'd9; rd_w_i = 5'd9;
        #1;
        vectors++;
        if ({forward_a_e_o, forward_b_e_o} !== 4'b1001) begin
            miscompares++;
            $display("[TB] FAIL fwd_split: got a=%b b=%b, need a=10 b=01", forward_a_e_o, forward_b_e_o);
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        @(negedge clk_i);
        result_src_e_i = 2'b01; rd_e_i = 5'd7; rs2_d_i = 5'd7;
        #1;
        vectors++;
        if ({stall_f_o, stall_d_o, stall_e_o, flush_d_o, flush_e_o, flush_m_o} !== 6'b110010) begin
            miscompares++;
            $display("[TB] FAIL load_use_ctrl: got %b, need 110010",
                     {stall_f_o, stall_d_o, stall_e_o, flush_d_o, flush_e_o, flush_m_o});
        end
        @(negedge clk_i);
        rd_e_i = 5'd0; rs2_d_i = 5'd0;
        #1;
        vectors++;
        if (stall_cnt_o !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL load_use_count: got %0d, need 1", stall_cnt_o);
        end
        vectors++;
        if ({stall_f_o, flush_e_o} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL load_use_rd0: got %b, need 00", {stall_f_o, flush_e_o});
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        @(negedge clk_i);
        pc_src_e_i = 1'b1;
        #1;
        vectors++;
        if ({stall_f_o, flush_d_o, flush_e_o, flush_m_o} !== 4'b0110) begin
            miscompares++;
            $display("[TB] FAIL branch_ctrl: got %b, need 0110", {stall_f_o, flush_d_o, flush_e_o, flush_m_o});
        end
        @(negedge clk_i);
        pc_src_e_i = 1'b0;
        #1;
        vectors++;
        if ({flush_cnt_o, flush_d_o} !== {32'd1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL branch_count: got cnt=%0d flush_d=%b, need cnt=1 flush_d=0", flush_cnt_o, flush_d_o);
        end
        pc_src_e_i = 1'b1; result_src_e_i = 2'b01; rd_e_i = 5'd7; rs1_d_i = 5'd7;
        #1;
        vectors++;
        if ({stall_f_o, stall_d_o, stall_e_o, flush_d_o, flush_e_o, flush_m_o} !== 6'b110110) begin
            miscompares++;
            $display("[TB] FAIL branch_load_use: got %b, need 110110",
                     {stall_f_o, stall_d_o, stall_e_o, flush_d_o, flush_e_o, flush_m_o});
        end
        @(negedge clk_i);
        clear_inputs();
        #1;
        vectors++;
        if ({stall_cnt_o, flush_cnt_o} !== {32'd2, 32'd2}) begin
            miscompares++;
            $display("[TB] FAIL branch_lw_counts: got %0d/%0d, need 2/2", stall_cnt_o, flush_cnt_o);
        end
    endtask

    // MC_LAT=4 runs one op over the four cycles while MC_LAT=2 runs two ops back to back.
    task automatic test_multicycle();
        logic [3:0] busy4, done4, busy2, done2;
        busy4 = 4'b0111; done4 = 4'b1000;
        busy2 = 4'b0101; done2 = 4'b1010;
        do_reset();
        @(negedge clk_i);
        mc_start_e_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            vectors++;
            if ({mc_busy_o, mc_done_o, stall_f_o, stall_d_o, stall_e_o, flush_m_o, flush_d_o, flush_e_o} !==
                {busy4[k], done4[k], busy4[k], busy4[k], busy4[k], busy4[k], 2'b00}) begin
                miscompares++;
                $display("[TB] FAIL mc4_cycle%0d: got %b, need %b", k,
                         {mc_busy_o, mc_done_o, stall_f_o, stall_d_o, stall_e_o, flush_m_o, flush_d_o, flush_e_o},
                         {busy4[k], done4[k], busy4[k], busy4[k], busy4[k], busy4[k], 2'b00});
            end
            vectors++;
            if ({mc_busy2, mc_done2, flush_m2} !== {busy2[k], done2[k], busy2[k]}) begin
                miscompares++;
                $display("[TB] FAIL mc2_cycle%0d: got %b, need %b", k,
                         {mc_busy2, mc_done2, flush_m2}, {busy2[k], done2[k], busy2[k]});
            end
            @(negedge clk_i);
        end
        mc_start_e_i = 1'b0;
        #1;
        vectors++;
        if ({mc_busy_o, mc_done_o, mc_busy2, mc_done2} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL mc_back_idle: got %b, need 0000", {mc_busy_o, mc_done_o, mc_busy2, mc_done2});
        end
        vectors++;
        if ({stall_cnt_o, stall_cnt2} !== {32'd3, 32'd2}) begin
            miscompares++;
            $display("[TB] FAIL mc_stall_counts: got %0d/%0d, need 3/2", stall_cnt_o, stall_cnt2);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        @(negedge clk_i);
        mc_start_e_i = 1'b1;
        @(negedge clk_i);
        mc_start_e_i = 1'b0;
        #1;
        vectors++;
        if (mc_busy_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_op_busy: got %b, need 1", mc_busy_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        vectors++;
        if ({mc_busy_o, mc_done_o, stall_e_o, flush_m_o, stall_cnt_o} !== {4'b0000, 32'd0}) begin
            miscompares++;
            $display("[TB] FAIL mid_op_reset: got %b cnt=%0d, need 0000 cnt=0",
                     {mc_busy_o, mc_done_o, stall_e_o, flush_m_o}, stall_cnt_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if ({mc_busy_o, mc_done_o} !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL mid_op_release%0d: got %b, need 00", k, {mc_busy_o, mc_done_o});
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_counter_wrap();
        @(negedge clk_i);
        clear_inputs();
        force dut4.stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut4.stall_cnt;
        #1;
        vectors++;
        if (stall_cnt_o !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("[TB] FAIL wrap_preload: got %h, need ffffffff", stall_cnt_o);
        end
        result_src_e_i = 2'b01; rd_e_i = 5'd4; rs1_d_i = 5'd4;
        @(negedge clk_i);
        clear_inputs();
        #1;
        vectors++;
        if (stall_cnt_o !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL wrap_stall_cnt: got %h, need 00000000", stall_cnt_o);
        end
    endtask

    initial begin
        clear_inputs();
        rst_i = 1'b1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_multicycle();
        test_reset_mid_op();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the RV32IMAFB five-stage pipeline. It generates stall and flush controls for the F/D, D/E and E/M pipeline registers and operand-forwarding selects for Execute. It also sequences multi-cycle Execute operations (M-extension divide, FPU) by holding the front end and inserting bubbles into the E/M control register until the unit finishes. Two saturating-free performance counters report stall and branch-flush cycles.

## Interface
Parameters:
- `MC_LAT`, default 32: total cycles a multi-cycle op occupies Execute. Legal range is 2 or more.
- `CNT_W`, default `$clog2(MC_LAT)`: width of the multi-cycle down-counter.

Ports (name, direction, width, meaning):
- `clk_i` in 1: the single clock. All state updates on the rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `rs1_d_i`, `rs2_d_i` in 5: source registers in Decode.
- `rs1_e_i`, `rs2_e_i`, `rd_e_i` in 5: source and destination registers in Execute.
- `rd_m_i`, `rd_w_i` in 5: destination registers in Memory and Writeback.
- `reg_write_m_i`, `reg_write_w_i` in 1: register-write enables in Memory and Writeback.
- `result_src_e_i` in 2: result source in Execute. The value `2'b01` means load.
- `pc_src_e_i` in 1: taken branch or jump resolved in Execute.
- `mc_start_e_i` in 1: the instruction in Execute is a multi-cycle op.
- `stall_f_o`, `stall_d_o`, `stall_e_o` out 1: hold the PC, the F/D register and the D/E register.
- `flush_d_o`, `flush_e_o`, `flush_m_o` out 1: clear the F/D, D/E and E/M registers. `flush_m_o` zeroes `mem_write`, `reg_write` and `result_src` in E/M.
- `forward_a_e_o`, `forward_b_e_o` out 2: operand source select. `00` selects the register file, `01` the Writeback result, `10` the Memory ALU result.
- `mc_busy_o` out 1: the multi-cycle op is still running.
- `mc_done_o` out 1: single-cycle pulse. The E/M register captures the op result this cycle.
- `stall_cnt_o` out 32: count of cycles in which `stall_f_o` was high.
- `flush_cnt_o` out 32: count of cycles in which `pc_src_e_i` caused a flush.

## Operation
- **Forwarding** (combinational, evaluated per operand; shown for A):
  - `10` if `reg_write_m_i`, `rd_m_i != 0` and `rd_m_i == rs1_e_i`.
  - Otherwise `01` if the same condition holds for the W stage.
  - Otherwise `00`.
  - Memory takes priority over Writeback.
- **Load-use stall:** `lw_stall = (result_src_e_i == 2'b01) & (rd_e_i != 0) & (rd_e_i == rs1_d_i | rd_e_i == rs2_d_i)`.
- **FSM states:** IDLE and BUSY, with down-counter `cnt`.
  - IDLE, `mc_start_e_i` = 1: assert `mc_stall`, load `cnt <= MC_LAT-2`, go to BUSY.
  - BUSY, `cnt != 0`: assert `mc_stall`, `cnt <= cnt-1`.
  - BUSY, `cnt == 0`: `mc_done_o` = 1, no `mc_stall`, go to IDLE.
  - `mc_start_e_i` is ignored while in BUSY.
- **Output equations:**
  - `mc_busy_o = mc_stall`.
  - `stall_f_o = stall_d_o = lw_stall | mc_stall`.
  - `stall_e_o = mc_stall`.
  - `flush_m_o = mc_stall`: one bubble per stalled cycle enters E/M.
  - `flush_d_o = pc_src_e_i & ~mc_stall`.
  - `flush_e_o = (lw_stall | pc_src_e_i) & ~mc_stall`.
- **Priority:**
  - `mc_stall` overrides load-use and branch effects on D and E.
  - `pc_src_e_i` during BUSY is illegal (the Execute op is not a branch); a bench assertion checks this.
  - When `flush_d_o` and `stall_d_o` are both high, the flush wins at the F/D register.
- **Counters:** `stall_cnt_o` increments on each cycle with `stall_f_o` high. `flush_cnt_o` increments on each `flush_d_o`. Both wrap modulo 2^32.

## Timing
- **Reset:** `rst_i` forces IDLE, `cnt` = 0 and both counters to 0 immediately.
  - While in reset, `mc_busy_o`, `mc_done_o`, `stall_e_o` and `flush_m_o` are 0.
  - Forward, load-use and branch outputs stay pure combinational functions of the inputs.
- **Reset mid-op:** the op is abandoned. There is no `mc_done_o` pulse, and the first cycle after release is IDLE.
- **Multi-cycle op:** it occupies Execute for exactly `MC_LAT` cycles.
  - Start cycle T plus `MC_LAT-2` BUSY cycles give `MC_LAT-1` stall cycles.
  - `mc_done_o` fires in cycle T+`MC_LAT-1`.
- **`MC_LAT` = 2:** BUSY lasts one cycle, with `cnt` = 0 and done.
- **Back-to-back ops:** a new op can start in the first IDLE cycle after done.
- **Combinational paths:** there is no latency on forwarding, load-use or branch paths. The FSM and counters are the only state.

## Structure
- **`hazard_pkg`:**
  - `fwd_sel_e` with values FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - `RESULT_SRC_LOAD` = 2'b01.
  - `mc_state_e` with values IDLE and BUSY.
- **Sub-module:** `forwarding_unit` (combinational), instantiated once and producing both selects. The FSM, stall/flush logic and counters stay in the top level.

## Test plan
- **Forwarding priority:** `rs1_e_i`=5, `rd_m_i`=5, `rd_w_i`=5, both writes set -> `forward_a_e_o`=`10`. Clear `reg_write_m_i` -> `01`. Then `rd_m_i`=`rd_w_i`=0 -> `00`.
- **Load-use:** `result_src_e_i`=01, `rd_e_i`=7, `rs2_d_i`=7 -> `stall_f_o`=`stall_d_o`=`flush_e_o`=1 for 1 cycle, `stall_cnt_o`=1. With `rd_e_i`=0 -> no stall.
- **Branch:** `pc_src_e_i` pulse of 1 cycle -> `flush_d_o`=`flush_e_o`=1 that cycle, `flush_cnt_o` 0->1. Combined with `lw_stall` -> `flush_d_o`=1 and `flush_e_o`=1.
- **Multi-cycle op, `MC_LAT`=4:** `mc_start_e_i` held -> stalls and `flush_m_o` high for 3 cycles, `mc_done_o` in the 4th cycle, `stall_cnt_o`=3. Repeat with `MC_LAT`=2 -> 1 stall cycle, done in the 2nd cycle.
- **Reset mid-op:** assert `rst_i` in the 2nd BUSY cycle -> all state outputs 0 immediately, counters 0, no `mc_done_o` after release.
- **Counter wrap:** preload or force `stall_cnt_o` to 32'hFFFF_FFFF, then one stall cycle -> 0.
